// File: rtl/mem_stage.sv
// mem_stage: load/store stage with a sync-read DMEM and a small I/O window.
// Loads take two cycles with one bubble; stores and ALU ops take one.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef IR_WIDTH
`define IR_WIDTH 32
`endif
`ifndef OP_LDB
`define OP_LDB 8'h39
`endif
`ifndef OP_LDW
`define OP_LDW 8'h3A
`endif
`ifndef OP_STB
`define OP_STB 8'h3B
`endif
`ifndef OP_STW
`define OP_STW 8'h3C
`endif

module mem_stage #(
    parameter int                    DMEM_AW  = 10,
    parameter logic [`REG_WIDTH-1:0] IO_BASE  = 16'hF000,
    parameter logic [`REG_WIDTH-1:0] LEDR_OFS = 16'd0,
    parameter logic [`REG_WIDTH-1:0] HEX_OFS  = 16'd2,
    parameter logic [`REG_WIDTH-1:0] SW_OFS   = 16'd4,
    parameter logic [`REG_WIDTH-1:0] KEY_OFS  = 16'd6
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET_N,
    input  logic                     I_LOCK,
    input  logic [`PC_WIDTH-1:0]     I_PC,
    input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [`IR_WIDTH-1:0]     I_IR,
    input  logic [3:0]               I_DestRegIdx,
    input  logic [`REG_WIDTH-1:0]    I_DestValue,
    input  logic [2:0]               I_CCValue,
    input  logic [`REG_WIDTH-1:0]    I_MARValue,
    input  logic [`REG_WIDTH-1:0]    I_MDRValue,
    input  logic                     I_EX_Valid,
    input  logic                     I_RegWEn,
    input  logic                     I_CCWEn,
    input  logic [9:0]               I_SW,
    input  logic [3:0]               I_KEY,
    output logic                     O_LOCK,
    output logic [`OPCODE_WIDTH-1:0] O_Opcode,
    output logic [`PC_WIDTH-1:0]     O_PC,
    output logic [`IR_WIDTH-1:0]     O_IR,
    output logic [3:0]               O_DestRegIdx,
    output logic [2:0]               O_CCValue,
    output logic [`REG_WIDTH-1:0]    O_DestValue,
    output logic                     O_MEM_Valid,
    output logic                     O_RegWEn,
    output logic                     O_CCWEn,
    output logic                     O_RegWEn_Signal,
    output logic                     O_CCWEn_Signal,
    output logic                     O_MEMStallSignal,
    output logic [9:0]               O_LEDR,
    output logic [15:0]              O_HEX
);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  act;
    logic                  is_ldw;
    logic                  is_ldb;
    logic                  is_stw;
    logic                  is_stb;
    logic                  is_load;
    logic                  is_store;
    logic                  is_io;
    logic                  lane;
    logic                  issue;
    logic                  finish;
    logic                  we_lo;
    logic                  we_hi;
    logic                  io_we;
    logic [DMEM_AW-1:0]    widx;
    logic [`REG_WIDTH-1:0] io_ofs;
    logic [`REG_WIDTH-1:0] io_rdata;
    logic [`REG_WIDTH-1:0] wdata;
    logic [`REG_WIDTH-1:0] rd_q;
    logic [`REG_WIDTH-1:0] ld_data;

    logic [`REG_WIDTH-1:0] dmem [0:(1<<DMEM_AW)-1];

    assign act      = I_LOCK & I_EX_Valid;
    assign is_ldw   = (I_Opcode == `OP_LDW);
    assign is_ldb   = (I_Opcode == `OP_LDB);
    assign is_stw   = (I_Opcode == `OP_STW);
    assign is_stb   = (I_Opcode == `OP_STB);
    assign is_load  = is_ldw | is_ldb;
    assign is_store = is_stw | is_stb;

    assign is_io  = (I_MARValue >= IO_BASE);
    assign io_ofs = I_MARValue - IO_BASE;
    assign widx   = I_MARValue[DMEM_AW:1];
    assign lane   = I_MARValue[0];

    assign O_RegWEn_Signal  = I_EX_Valid & I_RegWEn;
    assign O_CCWEn_Signal   = I_EX_Valid & I_CCWEn;
    // Reset kills the stall at once so a held load cannot re-stall.
    assign O_MEMStallSignal = issue & I_RESET_N;

    always_comb begin
        io_rdata = '0;
        if (io_ofs == SW_OFS) begin
            io_rdata = {{(`REG_WIDTH-10){1'b0}}, I_SW};
        end else if (io_ofs == KEY_OFS) begin
            io_rdata = {{(`REG_WIDTH-4){1'b0}}, I_KEY};
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        finish  = 1'b0;
        if (act && is_load) begin
            unique case (state_q)
                IDLE: begin
                    issue   = 1'b1;
                    state_d = LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (!I_RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign wdata = is_stb ? {I_MDRValue[7:0], I_MDRValue[7:0]} : I_MDRValue;
    assign we_lo = I_RESET_N & act & ~is_io & (is_stw | (is_stb & ~lane));
    assign we_hi = I_RESET_N & act & ~is_io & (is_stw | (is_stb & lane));
    assign io_we = I_RESET_N & act & is_io & is_store;

    // Byte-enabled write port plus registered read port.
    always_ff @(negedge I_CLOCK) begin
        if (we_lo) begin
            dmem[widx][7:0] <= wdata[7:0];
        end
        if (we_hi) begin
            dmem[widx][15:8] <= wdata[15:8];
        end
        if (issue) begin
            rd_q <= is_io ? io_rdata : dmem[widx];
        end
    end

    // Lane comes from the held MAR in LOAD_WAIT.
    assign ld_data = is_ldb
        ? {8'h00, (lane ? rd_q[15:8] : rd_q[7:0])}
        : rd_q;

    always_ff @(negedge I_CLOCK) begin
        if (!I_RESET_N) begin
            O_LOCK       <= 1'b0;
            O_Opcode     <= '0;
            O_PC         <= '0;
            O_IR         <= '0;
            O_DestRegIdx <= '0;
            O_CCValue    <= '0;
            O_DestValue  <= '0;
            O_MEM_Valid  <= 1'b0;
            O_RegWEn     <= 1'b0;
            O_CCWEn      <= 1'b0;
            O_LEDR       <= '0;
            O_HEX        <= '0;
        end else begin
            O_LOCK       <= I_LOCK;
            O_Opcode     <= I_Opcode;
            O_PC         <= I_PC;
            O_IR         <= I_IR;
            O_DestRegIdx <= I_DestRegIdx;
            O_CCValue    <= I_CCValue;
            O_DestValue  <= I_DestValue;
            O_MEM_Valid  <= 1'b0;
            O_RegWEn     <= 1'b0;
            O_CCWEn      <= 1'b0;
            if (act) begin
                unique case (1'b1)
                    is_load: begin
                        if (finish) begin
                            O_DestValue <= ld_data;
                            O_MEM_Valid <= 1'b1;
                            O_RegWEn    <= I_RegWEn;
                            O_CCWEn     <= I_CCWEn;
                        end
                    end
                    is_store: begin
                        O_MEM_Valid <= 1'b1;
                    end
                    default: begin
                        O_MEM_Valid <= 1'b1;
                        O_RegWEn    <= I_RegWEn;
                        O_CCWEn     <= I_CCWEn;
                    end
                endcase
            end
            if (io_we && io_ofs == LEDR_OFS) begin
                O_LEDR <= I_MDRValue[9:0];
            end
            if (io_we && io_ofs == HEX_OFS) begin
                O_HEX <= I_MDRValue[15:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboard of per-cycle expectations
// (combinational signals before the edge, registered outputs after).
`ifndef OP_LDB
`define OP_LDB 8'h39
`endif
`ifndef OP_LDW
`define OP_LDW 8'h3A
`endif
`ifndef OP_STB
`define OP_STB 8'h3B
`endif
`ifndef OP_STW
`define OP_STW 8'h3C
`endif
`define OP_ADD 8'h00

module tb_mem_stage;
    logic        clk = 1'b0;
    logic        I_RESET_N = 1'b0;
    logic        I_LOCK = 1'b0;
    logic [15:0] I_PC = '0;
    logic [7:0]  I_Opcode = '0;
    logic [31:0] I_IR = '0;
    logic [3:0]  I_DestRegIdx = '0;
    logic [15:0] I_DestValue = '0;
    logic [2:0]  I_CCValue = '0;
    logic [15:0] I_MARValue = '0;
    logic [15:0] I_MDRValue = '0;
    logic        I_EX_Valid = 1'b0;
    logic        I_RegWEn = 1'b0;
    logic        I_CCWEn = 1'b0;
    logic [9:0]  I_SW = '0;
    logic [3:0]  I_KEY = '0;
    logic        O_LOCK;
    logic [7:0]  O_Opcode;
    logic [15:0] O_PC;
    logic [31:0] O_IR;
    logic [3:0]  O_DestRegIdx;
    logic [2:0]  O_CCValue;
    logic [15:0] O_DestValue;
    logic        O_MEM_Valid;
    logic        O_RegWEn;
    logic        O_CCWEn;
    logic        O_RegWEn_Signal;
    logic        O_CCWEn_Signal;
    logic        O_MEMStallSignal;
    logic [9:0]  O_LEDR;
    logic [15:0] O_HEX;

    always #5 clk = ~clk;

    mem_stage dut (
        .I_CLOCK(clk), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
        .I_PC(I_PC), .I_Opcode(I_Opcode), .I_IR(I_IR),
        .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue),
        .I_CCValue(I_CCValue), .I_MARValue(I_MARValue),
        .I_MDRValue(I_MDRValue), .I_EX_Valid(I_EX_Valid),
        .I_RegWEn(I_RegWEn), .I_CCWEn(I_CCWEn), .I_SW(I_SW), .I_KEY(I_KEY),
        .O_LOCK(O_LOCK), .O_Opcode(O_Opcode), .O_PC(O_PC), .O_IR(O_IR),
        .O_DestRegIdx(O_DestRegIdx), .O_CCValue(O_CCValue),
        .O_DestValue(O_DestValue), .O_MEM_Valid(O_MEM_Valid),
        .O_RegWEn(O_RegWEn), .O_CCWEn(O_CCWEn),
        .O_RegWEn_Signal(O_RegWEn_Signal), .O_CCWEn_Signal(O_CCWEn_Signal),
        .O_MEMStallSignal(O_MEMStallSignal), .O_LEDR(O_LEDR), .O_HEX(O_HEX)
    );

    // ctl = {stall, rsig, csig, valid, regwen, ccwen}; dv checked when dvc=1
    typedef struct packed {
        logic        dvc;
        logic [5:0]  ctl;
        logic [15:0] dv;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];
    rec_t e;
    rec_t g;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] mem_m [int];
    logic [15:0] pc_n = 16'h0100;

    function automatic rec_t mk(input logic dvc, input logic [5:0] ctl,
                                input logic [15:0] dv);
        rec_t r;
        r.dvc = dvc;
        r.ctl = ctl;
        r.dv  = dv;
        return r;
    endfunction

    function automatic logic [15:0] model_load(input logic [7:0] op,
                                               input logic [15:0] mar);
        logic [15:0] w;
        int idx;
        w = 16'h0000;
        if (mar >= 16'hF000) begin
            if (mar - 16'hF000 == 16'd4) w = {6'b0, I_SW};
            else if (mar - 16'hF000 == 16'd6) w = {12'b0, I_KEY};
        end else begin
            idx = int'(mar[10:1]);
            if (mem_m.exists(idx)) w = mem_m[idx];
        end
        if (op == `OP_LDB) w = mar[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
        return w;
    endfunction

    task automatic model_store(input logic [7:0] op, input logic [15:0] mar,
                               input logic [15:0] mdr);
        int idx;
        logic [15:0] w;
        if (mar < 16'hF000) begin
            idx = int'(mar[10:1]);
            w = mem_m.exists(idx) ? mem_m[idx] : 16'h0000;
            if (op == `OP_STW) w = mdr;
            else if (mar[0]) w[15:8] = mdr[7:0];
            else w[7:0] = mdr[7:0];
            mem_m[idx] = w;
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [15:0] mar,
                         input logic [15:0] mdr, input logic [15:0] dv,
                         input logic rwe, input logic cwe,
                         input logic lck, input logic vld);
        I_Opcode    = op;
        I_MARValue  = mar;
        I_MDRValue  = mdr;
        I_DestValue = dv;
        I_RegWEn    = rwe;
        I_CCWEn     = cwe;
        I_LOCK      = lck;
        I_EX_Valid  = vld;
        I_PC        = pc_n;
        I_IR        = {op, 8'h5A, pc_n};
        pc_n        = pc_n + 16'd2;
    endtask

    task automatic cyc(input rec_t ex);
        rec_t r;
        exp_q.push_back(ex);
        #1;
        r.dvc = 1'b0;
        r.ctl[5:3] = {O_MEMStallSignal, O_RegWEn_Signal, O_CCWEn_Signal};
        @(negedge clk);
        @(posedge clk);
        r.ctl[2:0] = {O_MEM_Valid, O_RegWEn, O_CCWEn};
        r.dv = O_DestValue;
        got_q.push_back(r);
    endtask

    task automatic ld(input logic [7:0] op, input logic [15:0] mar);
        logic [15:0] v;
        v = model_load(op, mar);
        drive(op, mar, 16'h0000, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(mk(1'b0, 6'b110_000, 16'h0000));
        cyc(mk(1'b1, 6'b010_110, v));
    endtask

    task automatic st(input logic [7:0] op, input logic [15:0] mar,
                      input logic [15:0] mdr, input logic lck,
                      input logic vld);
        drive(op, mar, mdr, 16'h0000, 1'b0, 1'b0, lck, vld);
        cyc(mk(1'b1, {3'b000, lck & vld, 2'b00}, 16'h0000));
        if (lck & vld) model_store(op, mar, mdr);
    endtask

    task automatic test_reset;
        I_RESET_N = 1'b0;
        drive(`OP_LDW, 16'h0010, 16'h0, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(mk(1'b1, 6'b010_000, 16'h0000));
        cyc(mk(1'b1, 6'b010_000, 16'h0000));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL reset: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
        checks++;
        if ({O_LOCK, O_LEDR, O_HEX, O_PC, O_IR, O_Opcode} !== '0) begin
            errors++;
            $display("FAIL reset_regs: lock=%b ledr=%h hex=%h pc=%h expected all 0", O_LOCK, O_LEDR, O_HEX, O_PC);
        end
        I_RESET_N = 1'b1;
    endtask

    task automatic test_word;
        st(`OP_STW, 16'h0010, 16'h1234, 1'b1, 1'b1);
        ld(`OP_LDW, 16'h0010);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL word: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
    endtask

    task automatic test_byte;
        st(`OP_STB, 16'h0011, 16'h00AB, 1'b1, 1'b1);
        ld(`OP_LDW, 16'h0010);
        ld(`OP_LDB, 16'h0011);
        ld(`OP_LDB, 16'h0010);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL byte: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
    endtask

    task automatic test_io;
        st(`OP_STW, 16'h0000, 16'h1111, 1'b1, 1'b1);
        st(`OP_STW, 16'hF000, 16'h03FF, 1'b1, 1'b1);
        checks++;
        if (O_LEDR !== 10'h3FF) begin
            errors++; $display("FAIL ledr: got %h expected 3ff", O_LEDR);
        end
        st(`OP_STW, 16'hF002, 16'hBEEF, 1'b1, 1'b1);
        checks++;
        if (O_HEX !== 16'hBEEF) begin
            errors++; $display("FAIL hex: got %h expected beef", O_HEX);
        end
        st(`OP_STW, 16'hF00E, 16'h1234, 1'b1, 1'b1);
        checks++;
        if (O_LEDR !== 10'h3FF || O_HEX !== 16'hBEEF) begin
            errors++; $display("FAIL io_unmapped_st: ledr=%h hex=%h expected 3ff beef", O_LEDR, O_HEX);
        end
        I_SW = 10'h2A5;
        ld(`OP_LDW, 16'hF004);
        I_KEY = 4'hA;
        ld(`OP_LDW, 16'hF006);
        ld(`OP_LDW, 16'hF00E);
        ld(`OP_LDW, 16'h0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL io: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
    endtask

    task automatic test_gated;
        st(`OP_STW, 16'h0020, 16'h7777, 1'b1, 1'b1);
        st(`OP_STW, 16'h0020, 16'h5555, 1'b1, 1'b0);
        st(`OP_STW, 16'hF000, 16'h0000, 1'b1, 1'b0);
        st(`OP_STW, 16'h0020, 16'h5555, 1'b0, 1'b1);
        checks++;
        if (O_LOCK !== 1'b0 || O_LEDR !== 10'h3FF) begin
            errors++; $display("FAIL gated_regs: lock=%b ledr=%h expected 0 3ff", O_LOCK, O_LEDR);
        end
        drive(`OP_LDW, 16'h0020, 16'h0, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(mk(1'b0, 6'b010_000, 16'h0000));
        drive(`OP_LDW, 16'h0020, 16'h0, 16'h9999, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(mk(1'b0, 6'b000_000, 16'h0000));
        ld(`OP_LDW, 16'h0020);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL gated: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
    endtask

    task automatic test_reset_in_wait;
        drive(`OP_LDW, 16'h0010, 16'h0, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(mk(1'b0, 6'b110_000, 16'h0000));
        I_RESET_N = 1'b0;
        cyc(mk(1'b1, 6'b010_000, 16'h0000));
        cyc(mk(1'b1, 6'b010_000, 16'h0000));
        I_RESET_N = 1'b1;
        ld(`OP_LDW, 16'h0010);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL reset_wait: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
    endtask

    task automatic test_alu;
        logic [15:0] pc_e;
        I_CCValue    = 3'b101;
        I_DestRegIdx = 4'd9;
        drive(`OP_ADD, 16'h0000, 16'h0000, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1);
        pc_e = I_PC;
        cyc(mk(1'b1, 6'b011_111, 16'h0007));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL alu: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
        checks++;
        if (O_CCValue !== 3'b101 || O_DestRegIdx !== 4'd9 || O_PC !== pc_e || O_LOCK !== 1'b1) begin
            errors++;
            $display("FAIL alu_pass: cc=%b idx=%0d pc=%h lock=%b expected 101 9 %h 1", O_CCValue, O_DestRegIdx, O_PC, O_LOCK, pc_e);
        end
    endtask

    task automatic test_back_to_back;
        ld(`OP_LDW, 16'h0010);
        ld(`OP_LDB, 16'h0011);
        ld(`OP_LDB, 16'h0010);
        ld(`OP_LDW, 16'h0020);
        st(`OP_STB, 16'h0021, 16'h00CD, 1'b1, 1'b1);
        ld(`OP_LDW, 16'h0020);
        ld(`OP_LDB, 16'h0021);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g.ctl !== e.ctl || (e.dvc && g.dv !== e.dv)) begin
                errors++;
                $display("FAIL back_to_back: ctl=%b dv=%h expected ctl=%b dv=%h", g.ctl, g.dv, e.ctl, e.dv);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_io();
        test_gated();
        test_reset_in_wait();
        test_alu();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
